// File: rtl/apb_master_bridge.sv
// APB master bridge: turns a valid/ready command stream into APB SETUP/ACCESS
// transfers and returns a valid/ready response carrying read data, the slave
// error flag and a timeout flag. One transfer is in flight at a time, and the
// wait for pready is bounded by a counter.
module apb_master_bridge #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 16
) (
  input  logic              pclk,
  input  logic              prstn,
  // command stream
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [DATA_W-1:0] cmd_wdata,
  // response stream
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic              rsp_timeout,
  // APB master side
  output logic              psel,
  output logic              penable,
  output logic              pwrite,
  output logic [ADDR_W-1:0] paddr,
  output logic [DATA_W-1:0] pwdata,
  input  logic [DATA_W-1:0] prdata,
  input  logic              pready,
  input  logic              pslverr
);

  // A TIMEOUT of 0 disables the counter. It still needs at least one bit.
  localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT > 0) ? (TIMEOUT - 1) : 0);
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_ACCESS = 2'd2,
    ST_RESP   = 2'd3
  } state_e;

  state_e           state_q;
  logic [CNT_W-1:0] cnt_q;

  // Transfer FSM. Every APB and response output is driven from a register here.
  always_ff @(posedge pclk or negedge prstn) begin
    if (!prstn) begin
      state_q     <= ST_IDLE;
      cnt_q       <= {CNT_W{1'b0}};
      cmd_ready   <= 1'b0;
      rsp_valid   <= 1'b0;
      rsp_rdata   <= {DATA_W{1'b0}};
      rsp_err     <= 1'b0;
      rsp_timeout <= 1'b0;
      psel        <= 1'b0;
      penable     <= 1'b0;
      pwrite      <= 1'b0;
      paddr       <= {ADDR_W{1'b0}};
      pwdata      <= {DATA_W{1'b0}};
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (cmd_valid && cmd_ready) begin
            // Capture the command. A read drives zero write data onto the bus.
            paddr     <= cmd_addr;
            pwrite    <= cmd_write;
            pwdata    <= cmd_write ? cmd_wdata : {DATA_W{1'b0}};
            psel      <= 1'b1;
            penable   <= 1'b0;
            cmd_ready <= 1'b0;
            state_q   <= ST_SETUP;
          end else begin
            cmd_ready <= 1'b1;
          end
        end

        ST_SETUP: begin
          penable <= 1'b1;
          cnt_q   <= {CNT_W{1'b0}};
          state_q <= ST_ACCESS;
        end

        ST_ACCESS: begin
          if (pready) begin
            rsp_rdata   <= pwrite ? {DATA_W{1'b0}} : prdata;
            rsp_err     <= pslverr;
            rsp_timeout <= 1'b0;
            psel        <= 1'b0;
            penable     <= 1'b0;
            rsp_valid   <= 1'b1;
            state_q     <= ST_RESP;
          end else if ((TIMEOUT != 0) && (cnt_q == CNT_LAST)) begin
            // The slave stalled too long. Abort the transfer and flag it.
            rsp_rdata   <= {DATA_W{1'b0}};
            rsp_err     <= 1'b1;
            rsp_timeout <= 1'b1;
            psel        <= 1'b0;
            penable     <= 1'b0;
            rsp_valid   <= 1'b1;
            state_q     <= ST_RESP;
          end else if (cnt_q != CNT_MAX) begin
            cnt_q <= cnt_q + 1'b1;
          end else begin
            cnt_q <= cnt_q;
          end
        end

        ST_RESP: begin
          // Hold the response stable until the consumer takes it.
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            cmd_ready <= 1'b1;
            state_q   <= ST_IDLE;
          end else begin
            rsp_valid <= 1'b1;
          end
        end

        default: begin
          state_q   <= ST_IDLE;
          psel      <= 1'b0;
          penable   <= 1'b0;
          rsp_valid <= 1'b0;
          cmd_ready <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_apb_master_bridge.sv
// Directed bench for apb_master_bridge, driving a small APB RAM slave model.
// The slave model has programmable wait states, a hang mode, a forced-error
// mode and a forced-prdata mode.
module tb_apb_master_bridge;

  logic        pclk;
  logic        prstn;
  logic        cmd_valid;
  logic        cmd_ready;
  logic        cmd_write;
  logic [31:0] cmd_addr;
  logic [31:0] cmd_wdata;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic        rsp_timeout;
  logic        psel;
  logic        penable;
  logic        pwrite;
  logic [31:0] paddr;
  logic [31:0] pwdata;
  logic [31:0] prdata;
  logic        pready;
  logic        pslverr;

  int n_checks = 0;
  int n_fail   = 0;

  // Slave model controls
  int   wait_states = 0;
  logic hang        = 1'b0;
  logic err_force   = 1'b0;
  logic rd_override = 1'b0;
  int   acc_cnt     = 0;
  logic [31:0] ram [0:31];

  apb_master_bridge #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(16)) dut (
    .pclk(pclk), .prstn(prstn),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .rsp_err(rsp_err), .rsp_timeout(rsp_timeout),
    .psel(psel), .penable(penable), .pwrite(pwrite), .paddr(paddr),
    .pwdata(pwdata), .prdata(prdata), .pready(pready), .pslverr(pslverr)
  );

  initial pclk = 1'b0;
  always #5 pclk = ~pclk;

  // Slave: count the ACCESS cycles of the current transfer.
  always_ff @(posedge pclk) begin
    if (psel && penable && !pready) acc_cnt <= acc_cnt + 1;
    else                            acc_cnt <= 0;
  end

  // Slave: commit a write on the completing ACCESS edge.
  always_ff @(posedge pclk) begin
    if (psel && penable && pready && pwrite) ram[paddr[4:0]] <= pwdata;
  end

  assign pready  = !hang && (acc_cnt >= wait_states);
  assign pslverr = err_force;
  assign prdata  = rd_override ? (pready ? 32'hDEADBEEF : 32'h12345678)
                               : ram[paddr[4:0]];

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge pclk);
    #1;
  endtask

  // Issue one command with rsp_ready held high and return the response.
  task automatic run_xfer(input logic w, input logic [31:0] a, input logic [31:0] d,
                          output logic [31:0] rd, output logic er, output logic to);
    bit got;
    got = 1'b0;
    rd = 32'h0; er = 1'b0; to = 1'b0;
    rsp_ready = 1'b1;
    for (int k = 0; k < 10; k++) begin
      if (cmd_ready) begin got = 1'b1; break; end
      tick();
    end
    if (!got) check_eq("cmd_ready_wait", 64'd0, 64'd1);
    cmd_valid = 1'b1; cmd_write = w; cmd_addr = a; cmd_wdata = d;
    tick();
    cmd_valid = 1'b0;
    got = 1'b0;
    for (int k = 0; k < 60; k++) begin
      tick();
      if (rsp_valid) begin got = 1'b1; break; end
    end
    if (!got) check_eq("rsp_valid_wait", 64'd0, 64'd1);
    rd = rsp_rdata; er = rsp_err; to = rsp_timeout;
    tick();
  endtask

  initial begin
    logic [31:0] rd;
    logic        er;
    logic        to;
    int          pen_cnt;
    bit          got;

    prstn = 1'b0; cmd_valid = 1'b0; cmd_write = 1'b0;
    cmd_addr = 32'h0; cmd_wdata = 32'h0; rsp_ready = 1'b1;

    // Reset state
    #3;
    check_eq("rst_cmd_ready", cmd_ready, 1'b0);
    check_eq("rst_psel", {psel, penable, pwrite}, 3'b000);
    check_eq("rst_rsp", {rsp_valid, rsp_err, rsp_timeout}, 3'b000);
    check_eq("rst_paddr", paddr, 32'h0);
    check_eq("rst_rdata", rsp_rdata, 32'h0);
    tick();
    prstn = 1'b1;
    tick();
    check_eq("cmd_ready_after_rst", cmd_ready, 1'b1);

    // Write 0x5 to 0x3 with zero wait states, checked cycle by cycle
    cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 32'h3; cmd_wdata = 32'h5;
    tick();
    cmd_valid = 1'b0;
    check_eq("w_setup_ctl", {psel, penable, pwrite, cmd_ready}, 4'b1010);
    check_eq("w_setup_addr", paddr, 32'h3);
    check_eq("w_setup_wdata", pwdata, 32'h5);
    tick();
    check_eq("w_access_ctl", {psel, penable, cmd_ready}, 3'b110);
    check_eq("w_access_wdata", pwdata, 32'h5);
    tick();
    check_eq("w_rsp_ctl", {rsp_valid, rsp_err, rsp_timeout, psel, penable}, 5'b10000);
    check_eq("w_rsp_rdata", rsp_rdata, 32'h0);
    check_eq("w_rsp_cmd_ready", cmd_ready, 1'b0);
    tick();
    check_eq("w_done", {rsp_valid, cmd_ready}, 2'b01);
    check_eq("w_idle_hold", {paddr, pwdata}, {32'h3, 32'h5});

    // Write i to address i for 0..19, then read every address back
    for (int i = 0; i < 20; i++) begin
      run_xfer(1'b1, 32'(i), 32'(i), rd, er, to);
      check_eq("wr_err", {er, to}, 2'b00);
    end
    for (int i = 0; i < 20; i++) begin
      run_xfer(1'b0, 32'(i), 32'hFFFF_FFFF, rd, er, to);
      check_eq("rd_data", rd, 32'(i));
      check_eq("rd_err", {er, to}, 2'b00);
    end

    // Read with three wait states and forced prdata
    wait_states = 3; rd_override = 1'b1;
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 32'h7;
    tick();
    cmd_valid = 1'b0;
    pen_cnt = 0; got = 1'b0;
    for (int k = 0; k < 30; k++) begin
      tick();
      if (rsp_valid) begin got = 1'b1; break; end
      if (penable) pen_cnt++;
      check_eq("ws_paddr", {psel, paddr}, {1'b1, 32'h7});
    end
    check_eq("ws_got_rsp", got, 1'b1);
    check_eq("ws_penable_cycles", pen_cnt, 4);
    check_eq("ws_rdata", rsp_rdata, 32'hDEADBEEF);
    check_eq("ws_flags", {rsp_err, rsp_timeout}, 2'b00);
    tick();
    wait_states = 0; rd_override = 1'b0;

    // Slave error on a read
    err_force = 1'b1;
    run_xfer(1'b0, 32'h4, 32'h0, rd, er, to);
    check_eq("slverr_flags", {er, to}, 2'b10);
    check_eq("slverr_rdata", rd, 32'h4);
    err_force = 1'b0;

    // Slave hangs: abort after 16 ACCESS cycles
    hang = 1'b1; rd_override = 1'b1;
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 32'h2;
    tick();
    cmd_valid = 1'b0;
    pen_cnt = 0; got = 1'b0;
    for (int k = 0; k < 40; k++) begin
      tick();
      if (rsp_valid) begin got = 1'b1; break; end
      if (penable) pen_cnt++;
    end
    check_eq("to_got_rsp", got, 1'b1);
    check_eq("to_access_cycles", pen_cnt, 16);
    check_eq("to_flags", {rsp_err, rsp_timeout, psel, penable}, 4'b1100);
    check_eq("to_rdata", rsp_rdata, 32'h0);
    tick();
    hang = 1'b0; rd_override = 1'b0;

    // Response backpressure with a cmd_valid pulse during the wait
    rsp_ready = 1'b0;
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 32'h5;
    tick();
    cmd_valid = 1'b0;
    got = 1'b0;
    for (int k = 0; k < 10; k++) begin
      tick();
      if (rsp_valid) begin got = 1'b1; break; end
    end
    check_eq("bp_got_rsp", got, 1'b1);
    for (int k = 0; k < 5; k++) begin
      cmd_valid = (k == 1); cmd_write = 1'b1; cmd_addr = 32'h11; cmd_wdata = 32'h99;
      tick();
      check_eq("bp_hold", {rsp_valid, rsp_err, rsp_timeout, cmd_ready, psel}, 5'b10000);
      check_eq("bp_rdata", rsp_rdata, 32'h5);
    end
    cmd_valid = 1'b0;
    rsp_ready = 1'b1;
    tick();
    check_eq("bp_release", {rsp_valid, cmd_ready, psel}, 3'b010);
    tick();
    check_eq("bp_no_accept", {psel, paddr}, {1'b0, 32'h5});

    // Reset asserted in the middle of ACCESS
    wait_states = 5;
    cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 32'h9; cmd_wdata = 32'hAA;
    tick();
    cmd_valid = 1'b0;
    tick();
    check_eq("mr_in_access", {psel, penable}, 2'b11);
    #2 prstn = 1'b0;
    #1;
    check_eq("mr_async_drop", {psel, penable, rsp_valid, cmd_ready}, 4'b0000);
    @(negedge pclk);
    prstn = 1'b1;
    wait_states = 0;
    tick();
    check_eq("mr_cmd_ready", {cmd_ready, rsp_valid, psel}, 3'b100);
    run_xfer(1'b1, 32'h9, 32'h77, rd, er, to);
    check_eq("mr_write_flags", {er, to}, 2'b00);
    run_xfer(1'b0, 32'h9, 32'h0, rd, er, to);
    check_eq("mr_readback", rd, 32'h77);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/apb_master_bridge.md
Name: apb_master_bridge

Overview:
- Upstream APB requester that drives the APB RAM slave.
- Converts a simple valid/ready command stream (write or read, address, data) into APB SETUP/ACCESS phases.
- Returns a valid/ready response carrying read data, the slave error flag and a timeout flag.
- One outstanding transfer at a time; bounded wait on pready via a timeout counter.

Parameters:
- ADDR_W, 32, APB/command address width.
- DATA_W, 32, APB/command data width.
- TIMEOUT, 16, maximum ACCESS cycles to wait for pready; 0 disables the timeout.

Ports:
- pclk  in  1  APB clock, all logic on rising edge
- prstn  in  1  reset, asynchronous, active-low
- cmd_valid  in  1  command request
- cmd_ready  out  1  bridge can accept a command
- cmd_write  in  1  1=write, 0=read
- cmd_addr  in  ADDR_W  transfer address
- cmd_wdata  in  DATA_W  write data
- rsp_valid  out  1  response available
- rsp_ready  in  1  response consumer ready
- rsp_rdata  out  DATA_W  read data (0 for writes/timeouts)
- rsp_err  out  1  pslverr sampled or timeout
- rsp_timeout  out  1  transfer aborted by timeout
- psel, penable, pwrite  out  1 each  APB controls
- paddr  out  ADDR_W  APB address
- pwdata  out  DATA_W  APB write data
- prdata  in  DATA_W  APB read data
- pready  in  1  slave ready
- pslverr  in  1  slave error

Behaviour:
- Clock pclk; reset prstn is asynchronous, active-low. All outputs and state are registered.
- Reset values: state IDLE; cmd_ready, rsp_valid, rsp_err, rsp_timeout, psel, penable, pwrite = 0; paddr, pwdata, rsp_rdata = 0; wait counter = 0.
- States: IDLE, SETUP, ACCESS, RESP.
- IDLE:
  - cmd_ready=1 from the first edge after reset release.
  - On cmd_valid&&cmd_ready: capture write/addr/wdata, load paddr, pwrite, and pwdata (wdata for writes, 0 for reads); psel<=1, penable<=0, cmd_ready<=0; go to SETUP.
- SETUP: exactly one cycle. penable<=1; go to ACCESS; wait counter<=0.
- ACCESS: psel=penable=1; paddr/pwrite/pwdata stable.
  - pready=1 at the edge: rsp_rdata<=(read ? prdata : 0), rsp_err<=pslverr, rsp_timeout<=0, psel<=0, penable<=0, rsp_valid<=1; go to RESP.
  - pready=0 and TIMEOUT!=0 and counter==TIMEOUT-1: abort. rsp_rdata<=0, rsp_err<=1, rsp_timeout<=1; psel/penable<=0; rsp_valid<=1; go to RESP.
  - Otherwise counter increments (width clog2(TIMEOUT+1), never wraps).
- RESP: rsp_* held stable while rsp_valid=1 and rsp_ready=0. On rsp_ready: rsp_valid<=0, cmd_ready<=1, go to IDLE.
- Latency:
  - Command accepted at edge N: psel high after N, penable high after N+1.
  - With zero wait states (pready=1 at edge N+2), rsp_valid rises after N+2.
  - Minimum 4 cycles per transfer; no pipelining, no back-to-back ACCESS.
- Idle bus:
  - paddr/pwrite/pwdata hold their last values while psel=0.
  - pslverr/prdata are ignored outside ACCESS with pready=1.
- cmd_* inputs are ignored when cmd_ready=0; the command must not change the in-flight transfer.
- Reset mid-transfer: psel/penable/rsp_valid drop asynchronously; the pending transfer is discarded with no response. After release the block restarts in IDLE.
- rsp_ready high while rsp_valid=0 has no effect.

Test Plan:
- Write 0x5 to addr 0x3, pready tied 1:
  - psel rises one cycle after accept; penable the next cycle; pwdata=0x5 on both cycles.
  - rsp_valid with rsp_err=0, rsp_rdata=0; 4 cycles accept-to-next-cmd_ready.
- Write addr i data i for i=0..19, then read addr 0..19 from the APB RAM: each read rsp_rdata==i, rsp_err=0.
- Read with pready low for 3 ACCESS cycles: penable high for exactly 4 cycles, and paddr stays stable throughout. prdata=0xDEADBEEF is sampled only on the pready cycle and returned.
- pslverr=1 with pready=1: rsp_err=1, rsp_timeout=0. TIMEOUT=16 with pready held 0: abort after 16 ACCESS cycles with rsp_err=1, rsp_timeout=1, rsp_rdata=0, psel=0.
- Response backpressure: rsp_ready=0 for 5 cycles, then 1. rsp_* stay constant and cmd_ready stays 0 until the handshake; a cmd_valid pulse during the wait is not accepted.
- Assert prstn low in ACCESS (between edges): psel/penable/rsp_valid go 0 immediately. After release cmd_ready=1 after one edge, and the next write completes normally.
